// File: rtl/clock_display_driver_if.sv
// Bundle carrying the BCD time inputs, adjust/tick controls and the
// multiplexed 7-segment drive outputs of the clock display driver.
`timescale 1ns/1ps
interface clock_display_driver_if;
    logic [1:0] hours_tenth;
    logic [3:0] hours_units;
    logic [2:0] minutes_tenth;
    logic [3:0] minutes_units;
    logic       adjust_enable_hours;
    logic       adjust_enable_minutes;
    logic       sec_tick;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output hours_tenth, hours_units, minutes_tenth, minutes_units,
        output adjust_enable_hours, adjust_enable_minutes, sec_tick,
        input  anode, seg, dp
    );

    modport slave (
        input  hours_tenth, hours_units, minutes_tenth, minutes_units,
        input  adjust_enable_hours, adjust_enable_minutes, sec_tick,
        output anode, seg, dp
    );
endinterface

// File: rtl/clock_display_driver.sv
// Four-digit multiplexed 7-segment HH:MM driver with frame-coherent input
// shadowing, adjust blinking, leading-zero suppression and a seconds colon.
`timescale 1ns/1ps
module clock_display_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input logic                   clk,
    input logic                   rst,
    clock_display_driver_if.slave bus
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [RW-1:0] refresh_cnt;
    logic [BW-1:0] blink_cnt;
    logic [1:0]    idx;
    logic          blink_phase;
    logic          colon_on;
    logic          step;
    logic          blink_tc;

    logic [1:0] hours_tenth_sh;
    logic [3:0] hours_units_sh;
    logic [2:0] minutes_tenth_sh;
    logic [3:0] minutes_units_sh;

    logic [3:0] anode_p1;
    logic [6:0] seg_p1;
    logic       dp_p1;

    logic [3:0] cur_val;
    logic [3:0] cur_max;
    logic       cur_blank;
    logic [3:0] anode_d;
    logic [6:0] seg_d;
    logic       dp_d;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = SEG_DASH;
        endcase
    endfunction

    // Tens positions have tighter legal ranges than the units glyph table.
    function automatic logic [6:0] digit_seg(input logic [3:0] v, input logic [3:0] max_v);
        digit_seg = (v > max_v) ? SEG_DASH : glyph(v);
    endfunction

    assign step     = (refresh_cnt == REFRESH_LAST);
    assign blink_tc = (blink_cnt == BLINK_LAST);

    always_comb begin
        cur_val   = minutes_units_sh;
        cur_max   = 4'd9;
        cur_blank = bus.adjust_enable_minutes & blink_phase;
        case (idx)
            2'd1: begin
                cur_val   = {1'b0, minutes_tenth_sh};
                cur_max   = 4'd5;
                cur_blank = bus.adjust_enable_minutes & blink_phase;
            end
            2'd2: begin
                cur_val   = hours_units_sh;
                cur_max   = 4'd9;
                cur_blank = bus.adjust_enable_hours & blink_phase;
            end
            2'd3: begin
                cur_val   = {2'b00, hours_tenth_sh};
                cur_max   = 4'd2;
                cur_blank = (bus.adjust_enable_hours & blink_phase) | (hours_tenth_sh == 2'd0);
            end
            default: ;
        endcase
        anode_d = ~(4'b0001 << idx);
        seg_d   = cur_blank ? SEG_BLANK : digit_seg(cur_val, cur_max);
        dp_d    = ~((idx == 2'd2) & colon_on);
    end

    // Scan timing, frame snapshot and blink/colon state.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt      <= '0;
            blink_cnt        <= '0;
            idx              <= 2'd0;
            blink_phase      <= 1'b0;
            colon_on         <= 1'b1;
            hours_tenth_sh   <= '0;
            hours_units_sh   <= '0;
            minutes_tenth_sh <= '0;
            minutes_units_sh <= '0;
        end else begin
            refresh_cnt <= step ? '0 : refresh_cnt + RW'(1);
            blink_cnt   <= blink_tc ? '0 : blink_cnt + BW'(1);
            if (blink_tc)
                blink_phase <= ~blink_phase;
            if (step) begin
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    hours_tenth_sh   <= bus.hours_tenth;
                    hours_units_sh   <= bus.hours_units;
                    minutes_tenth_sh <= bus.minutes_tenth;
                    minutes_units_sh <= bus.minutes_units;
                end
            end
            if (bus.adjust_enable_hours | bus.adjust_enable_minutes)
                colon_on <= 1'b1;
            else if (bus.sec_tick)
                colon_on <= ~colon_on;
        end
    end

    // Output stage: one register between scan state and the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            anode_p1 <= 4'b1111;
            seg_p1   <= SEG_BLANK;
            dp_p1    <= 1'b1;
        end else begin
            anode_p1 <= anode_d;
            seg_p1   <= seg_d;
            dp_p1    <= dp_d;
        end
    end

    assign bus.anode = anode_p1;
    assign bus.seg   = seg_p1;
    assign bus.dp    = dp_p1;
endmodule
